pdm_audio_tx: RTL and testbench
===============================

# pdm_audio_tx

Playback-side counterpart to the on-board microphone capture path. Accepts signed 16-bit PCM samples over a valid/ready stream, buffers them in a small FIFO and converts them with a first-order sigma-delta modulator into the 1-bit density stream that drives `AUD_PWM` and the audio amplifier shutdown pin (`AUD_SD`). The block sits beside the mic path inside the embedded system, clocked from the 100 MHz system clock.

## Interface
- `CLK_DIV`, 32: system clocks per output bit; 100 MHz / 32 gives a 3.125 MHz bit rate. Must be ≥ 2.
- `OSR`, 64: bit ticks per PCM sample; 3.125 MHz / 64 gives 48.828 kHz. Must be ≥ 2.
- `FIFO_DEPTH`, 4: sample FIFO entries. Must be a power of two.
- `sysclk` in 1: system clock, 100 MHz.
- `sysreset_n` in 1: reset, asynchronous assert, active-low.
- `enable` in 1: level; 1 = play, 0 = stop and flush.
- `s_tdata` in 16: signed two's-complement PCM sample.
- `s_tvalid` in 1: sample valid.
- `s_tready` out 1: FIFO can accept a sample.
- `aud_pwm` out 1: registered modulator bit, routed to `AUD_PWM`.
- `aud_sd` out 1: amplifier enable, 1 = on, routed to `AUD_SD`.
- `underrun` out 1: one-cycle pulse when a sample fetch finds the FIFO empty.
- `fifo_level` out $clog2(FIFO_DEPTH)+1: current FIFO occupancy.

## Operation
- **Transfer:** a sample is transferred on a cycle where `s_tvalid && s_tready`. `s_tready = (state != IDLE) && (fifo_level < FIFO_DEPTH)`. A pop in the same cycle does not raise `s_tready`, so there is no full-bypass path.
- **States:**
  - IDLE: `enable = 0`. FIFO empty, counters 0, accumulator 0, `aud_pwm = 0`, `aud_sd = 0`.
  - PRIME: entered from IDLE when `enable = 1`. Waits for `fifo_level ≥ 1`, then pops the sample into `cur`, clears the divider and OSR counters, and moves to RUN.
  - RUN: `aud_sd = 1`. The modulator runs.
  - From any state, `enable = 0` returns to IDLE on the next clock. The FIFO is flushed and in-flight data is discarded.
- **Bit tick:**
  - `div_cnt` counts 0..CLK_DIV-1 and wraps. `tick` is asserted when `div_cnt == CLK_DIV-1`.
  - On each tick in RUN: `u = cur ^ 16'h8000` (offset binary), `sum[16:0] = acc + u`, `acc <= sum[15:0]`, `aud_pwm <= sum[16]`.
- **Sample fetch:**
  - `osr_cnt` counts ticks 0..OSR-1 and wraps. On the tick where `osr_cnt == OSR-1`, after the modulator update above, `cur` is reloaded.
  - If the FIFO is not empty, pop it into `cur`.
  - If the FIFO is empty, set `cur <= 16'h0000` (midscale) and pulse `underrun` for 1 cycle. The state stays RUN.
  - A push and a pop in the same cycle on an empty FIFO counts as an underrun, because there is no empty-bypass path. The pushed sample is retained.
- **Arithmetic:** `acc` is 16 bits and wraps modulo 2^16. The carry is the output bit. Output density is u/65536 with no saturation needed.

## Timing
- **Reset values:** `aud_pwm = 0`, `aud_sd = 0`, `underrun = 0`, `s_tready = 0`, `fifo_level = 0`, state IDLE.
- **Enable path:**
  - `enable` rising: `s_tready = 1` on the next cycle.
  - First push: PRIME pops it 1 cycle after it is written.
  - RUN entered the following cycle; `aud_sd = 1` from that cycle.
  - First `aud_pwm` update CLK_DIV cycles after RUN entry.
- **Output timing:** `aud_pwm` changes only on the cycle after a tick and holds for exactly CLK_DIV cycles.
- **Status timing:** `underrun` is asserted in the cycle after the fetch tick. `fifo_level` updates the cycle after a push or pop.
- **Reset mid-operation:** asynchronous clear to the reset values; no glitch beyond the reset edge itself.

## Structure
- **Shared package** `audio_pkg`:
  - `PCM_W = 16`
  - `PCM_MIDSCALE = 16'h0000`
  - `OFFSET_XOR = 16'h8000`
  - state enum `pdm_tx_state_t {IDLE, PRIME, RUN}`
- **Sub-module:** `sync_fifo` (parameters width and depth; push/pop/full/empty/level; asynchronous active-low reset; synchronous flush input). It is reusable by the capture path.
- **Top-level wiring:** the top level ties `AUD_SD` to `aud_sd` instead of a constant.

## Test plan
- **Zero input:** enable, push 0x0000 → `aud_pwm` alternates 0,1,0,1… per tick, beginning with 0; 32 ones in 64 ticks.
- **Positive full scale:** push 0x7FFF → first tick 0, next 63 ticks 1.
- **Negative full scale:** push 0x8000 → all 64 bits 0; then push 0x4000 → 48 ones per 64 ticks.
- **Underrun:** push a single sample, hold `s_tvalid = 0` → one `underrun` pulse at tick 64 and every OSR ticks thereafter; output alternates (midscale); `aud_sd` stays 1.
- **Backpressure:** enable with `s_tvalid` held high continuously → 5 samples accepted (1 into `cur`, 4 in FIFO), then `s_tready = 0` until the tick-64 pop, after which exactly 1 more is accepted.
- **Stop and reset:**
  - Drop `enable` mid-sample → next cycle `aud_pwm = 0`, `aud_sd = 0`, `fifo_level = 0`, `s_tready = 0`.
  - Assert `sysreset_n = 0` asynchronously mid-tick → all outputs reach their reset values before the next clock edge.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared definitions for the audio capture and playback paths.
package audio_pkg;

  localparam int PCM_W = 16;

  // Midscale in two's complement; loaded into the modulator when the FIFO runs dry.
  localparam logic [PCM_W-1:0] PCM_MIDSCALE = 16'h0000;

  // Flipping the sign bit maps signed PCM onto an unsigned 0..65535 density.
  localparam logic [PCM_W-1:0] OFFSET_XOR = 16'h8000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } pdm_tx_state_t;

  // Signed PCM to offset binary: -32768 -> 0, 0 -> 32768, 32767 -> 65535.
  function automatic logic [PCM_W-1:0] to_offset_binary(input logic [PCM_W-1:0] pcm);
    return pcm ^ OFFSET_XOR;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead read data, occupancy count and a
// synchronous flush. Shared between the capture and playback paths.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_flush,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_wdata,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_rdata,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_level;
  logic             w_wr_en;
  logic             w_rd_en;

  // Full and empty requests are ignored rather than corrupting the pointers.
  assign w_wr_en = i_push && !o_full;
  assign w_rd_en = i_pop  && !o_empty;

  // Sample storage.
  // NOTE: the array has no reset; r_level says which entries are live, so stale
  // contents are never observed and the storage can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  // Pointers and occupancy; DEPTH is a power of two so the pointers wrap naturally.
  // NOTE: every sequential assignment is non-blocking so all registers update
  // from the same pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_rd_en) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_wr_en, w_rd_en})
        2'b10:   r_level <= r_level + (AW+1)'(1);
        2'b01:   r_level <= r_level - (AW+1)'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_full  = (r_level == (AW+1)'(DEPTH));
  assign o_empty = (r_level == '0);
  assign o_level = r_level;

endmodule

// File: rtl/pdm_audio_tx.sv
// PCM-to-PDM playback path: a valid/ready sample stream feeds a small FIFO,
// and a first-order sigma-delta modulator turns each sample into a 1-bit
// density stream for the amplifier. aud_sd follows the RUN state so the
// amplifier is only powered while real modulation is running.
module pdm_audio_tx
  import audio_pkg::*;
#(
  parameter int CLK_DIV    = 32,
  parameter int OSR        = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        sysclk,
  input  logic                        sysreset_n,
  input  logic                        enable,
  input  logic [PCM_W-1:0]            s_tdata,
  input  logic                        s_tvalid,
  output logic                        s_tready,
  output logic                        aud_pwm,
  output logic                        aud_sd,
  output logic                        underrun,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int OSR_W = $clog2(OSR);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [OSR_W-1:0] OSR_LAST = OSR_W'(OSR - 1);

  pdm_tx_state_t r_state;
  pdm_tx_state_t w_state_next;

  logic [DIV_W-1:0] r_div_cnt;
  logic [OSR_W-1:0] r_osr_cnt;
  logic [PCM_W-1:0] r_acc;
  logic [PCM_W-1:0] r_cur;
  logic             r_aud_pwm;
  logic             r_underrun;

  logic             w_accepting;
  logic             w_prime_load;
  logic             w_run;
  logic             w_tick;
  logic             w_fetch;
  logic             w_push;
  logic             w_pop;
  logic             w_flush;
  logic [PCM_W:0]   w_sum;

  logic [PCM_W-1:0]             w_fifo_rdata;
  logic                         w_fifo_full;
  logic                         w_fifo_empty;
  logic [$clog2(FIFO_DEPTH):0]  w_fifo_level;

  // State register.
  always_ff @(posedge sysclk or negedge sysreset_n) begin
    if (!sysreset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state: dropping enable always stops; PRIME waits for the first sample.
  // NOTE: the default assignment at the top keeps this block purely
  // combinational; without it an unassigned path would infer a latch.
  always_comb begin
    w_state_next = r_state;
    if (!enable) begin
      w_state_next = IDLE;
    end else begin
      case (r_state)
        IDLE:    w_state_next = PRIME;
        PRIME:   if (!w_fifo_empty) w_state_next = RUN;
        RUN:     w_state_next = RUN;
        default: w_state_next = IDLE;
      endcase
    end
  end

  // State-decoded outputs: stream acceptance, PRIME load strobe, amplifier enable.
  always_comb begin
    w_accepting  = 1'b0;
    w_prime_load = 1'b0;
    w_run        = 1'b0;
    case (r_state)
      PRIME: begin
        w_accepting  = 1'b1;
        w_prime_load = !w_fifo_empty;
      end
      RUN: begin
        w_accepting = 1'b1;
        w_run       = 1'b1;
      end
      default: ;
    endcase
  end

  // Readiness depends only on registered state, so a pop never opens the door
  // in the same cycle and there is no combinational path from the modulator.
  assign s_tready = w_accepting && !w_fifo_full;
  assign w_push   = s_tvalid && s_tready;
  assign w_flush  = !enable;

  assign w_tick  = w_run && (r_div_cnt == DIV_LAST);
  assign w_fetch = w_tick && (r_osr_cnt == OSR_LAST);
  assign w_pop   = enable && (w_prime_load || (w_fetch && !w_fifo_empty));

  // 17-bit sum: the low 16 bits become the new accumulator, the carry is the output bit.
  assign w_sum = {1'b0, r_acc} + {1'b0, to_offset_binary(r_cur)};

  // Bit-rate divider, oversampling counter, modulator and sample reload.
  always_ff @(posedge sysclk or negedge sysreset_n) begin
    if (!sysreset_n) begin
      r_div_cnt  <= '0;
      r_osr_cnt  <= '0;
      r_acc      <= '0;
      r_cur      <= PCM_MIDSCALE;
      r_aud_pwm  <= 1'b0;
      r_underrun <= 1'b0;
    end else if (w_flush) begin
      r_div_cnt  <= '0;
      r_osr_cnt  <= '0;
      r_acc      <= '0;
      r_cur      <= PCM_MIDSCALE;
      r_aud_pwm  <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_underrun <= 1'b0;
      if (w_prime_load) begin
        r_cur     <= w_fifo_rdata;
        r_div_cnt <= '0;
        r_osr_cnt <= '0;
      end else if (w_run) begin
        r_div_cnt <= w_tick ? '0 : r_div_cnt + DIV_W'(1);
        if (w_tick) begin
          {r_aud_pwm, r_acc} <= w_sum;
          r_osr_cnt          <= w_fetch ? '0 : r_osr_cnt + OSR_W'(1);
          // The reload lands after this tick's update, which still used the old sample.
          if (w_fetch) begin
            if (!w_fifo_empty) begin
              r_cur <= w_fifo_rdata;
            end else begin
              r_cur      <= PCM_MIDSCALE;
              r_underrun <= 1'b1;
            end
          end
        end
      end
    end
  end

  sync_fifo #(
    .WIDTH (PCM_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (sysclk),
    .rst_n   (sysreset_n),
    .i_flush (w_flush),
    .i_push  (w_push),
    .i_wdata (s_tdata),
    .i_pop   (w_pop),
    .o_rdata (w_fifo_rdata),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_level (w_fifo_level)
  );

  assign aud_pwm    = r_aud_pwm;
  assign aud_sd     = w_run;
  assign underrun   = r_underrun;
  assign fifo_level = w_fifo_level;

endmodule

// File: tb/tb_pdm_audio_tx.sv
// Bench for pdm_audio_tx: a queue-based behavioural model checked on every
// cycle, plus directed scenarios with hand-derived bit counts and timings.
module tb_pdm_audio_tx;

  localparam int CLK_DIV    = 32;
  localparam int OSR        = 64;
  localparam int FIFO_DEPTH = 4;
  localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1;

  logic             sysclk     = 1'b0;
  logic             sysreset_n = 1'b0;
  logic             enable     = 1'b0;
  logic [15:0]      s_tdata    = '0;
  logic             s_tvalid   = 1'b0;
  logic             s_tready;
  logic             aud_pwm;
  logic             aud_sd;
  logic             underrun;
  logic [LVL_W-1:0] fifo_level;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 sysclk = ~sysclk;

  pdm_audio_tx #(
    .CLK_DIV    (CLK_DIV),
    .OSR        (OSR),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .sysclk     (sysclk),
    .sysreset_n (sysreset_n),
    .enable     (enable),
    .s_tdata    (s_tdata),
    .s_tvalid   (s_tvalid),
    .s_tready   (s_tready),
    .aud_pwm    (aud_pwm),
    .aud_sd     (aud_sd),
    .underrun   (underrun),
    .fifo_level (fifo_level)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Playback is described as "cycles since playback began" (m_k): a bit is
  // produced every CLK_DIV cycles and a new sample is taken every OSR bits.
  // Density arithmetic uses plain integers: u = sample + 32768.
  typedef enum {M_OFF, M_WAIT, M_PLAY} mphase_t;

  mphase_t m_phase = M_OFF;
  int      q[$];
  int      m_cur   = 0;
  int      m_acc   = 0;
  int      m_k     = 0;
  bit      m_pwm   = 1'b0;
  bit      m_und   = 1'b0;
  bit      mp_push;
  int      mp_sum;

  always @(posedge sysclk or negedge sysreset_n) begin
    if (!sysreset_n) begin
      m_phase = M_OFF;
      q.delete();
      m_cur = 0; m_acc = 0; m_k = 0; m_pwm = 1'b0; m_und = 1'b0;
    end else begin
      mp_push = s_tvalid && (m_phase != M_OFF) && (q.size() < FIFO_DEPTH);
      if (!enable) begin
        m_phase = M_OFF;
        q.delete();
        m_cur = 0; m_acc = 0; m_k = 0; m_pwm = 1'b0; m_und = 1'b0;
      end else begin
        m_und = 1'b0;
        case (m_phase)
          M_OFF: m_phase = M_WAIT;
          M_WAIT: begin
            if (q.size() > 0) begin
              m_cur   = q.pop_front();
              m_k     = 0;
              m_phase = M_PLAY;
            end
          end
          M_PLAY: begin
            if (m_k % CLK_DIV == CLK_DIV - 1) begin
              mp_sum = m_acc + m_cur + 32768;
              m_pwm  = (mp_sum >= 65536);
              m_acc  = mp_sum % 65536;
              if ((m_k / CLK_DIV) % OSR == OSR - 1) begin
                if (q.size() > 0) begin
                  m_cur = q.pop_front();
                end else begin
                  m_cur = 0;
                  m_und = 1'b1;
                end
              end
            end
            m_k++;
          end
          default: ;
        endcase
        if (mp_push) q.push_back(int'($signed(s_tdata)));
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge sysclk) begin
    check("model_aud_pwm",    32'(aud_pwm),    32'(m_pwm));
    check("model_aud_sd",     32'(aud_sd),     32'(m_phase == M_PLAY));
    check("model_underrun",   32'(underrun),   32'(m_und));
    check("model_s_tready",   32'(s_tready),   32'((m_phase != M_OFF) && (q.size() < FIFO_DEPTH)));
    check("model_fifo_level", 32'(fifo_level), 32'(q.size()));
  end

  // ---------------- stimulus helpers ----------------
  // All helpers begin and end 1 ns after a rising edge unless noted.
  task automatic start_fresh();
    enable   = 1'b0;
    s_tvalid = 1'b0;
    repeat (3) begin
      @(posedge sysclk); #1;
    end
    enable = 1'b1;
  endtask

  task automatic push_sample(input logic [15:0] d);
    int  n;
    bit  took;
    n        = 0;
    took     = 1'b0;
    s_tvalid = 1'b1;
    s_tdata  = d;
    do begin
      @(negedge sysclk);
      took = s_tready;
      @(posedge sysclk); #1;
      n++;
    end while (!took && n < 200);
    s_tvalid = 1'b0;
    check("push_accepted", 32'(took), 32'd1);
  endtask

  // Ends on the falling edge of the first cycle with aud_sd high.
  task automatic wait_run();
    int n;
    n = 0;
    do begin
      @(negedge sysclk);
      n++;
    end while (!aud_sd && n < 100);
    check("run_entry_seen", 32'(aud_sd), 32'd1);
  endtask

  // Samples aud_pwm once per output bit, CLK_DIV cycles apart.
  task automatic collect_bits(input int nbits, output int ones, output logic b0, output logic b1);
    ones = 0; b0 = 1'b0; b1 = 1'b0;
    for (int j = 0; j < nbits; j++) begin
      repeat (CLK_DIV) @(negedge sysclk);
      if (j == 0) b0 = aud_pwm;
      if (j == 1) b1 = aud_pwm;
      if (aud_pwm) ones++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int   ones, n_acc, n_early, first_und, n_und, sd_low;
    logic b0, b1;

    // Reset values while reset is held.
    repeat (3) @(posedge sysclk);
    #1;
    check("rst_aud_pwm",    32'(aud_pwm),    32'd0);
    check("rst_aud_sd",     32'(aud_sd),     32'd0);
    check("rst_underrun",   32'(underrun),   32'd0);
    check("rst_s_tready",   32'(s_tready),   32'd0);
    check("rst_fifo_level", 32'(fifo_level), 32'd0);
    sysreset_n = 1'b1;
    @(posedge sysclk); #1;

    // Zero input: alternating bits starting with 0; also ready one cycle after enable.
    start_fresh();
    @(negedge sysclk);
    check("en_ready_same_cycle", 32'(s_tready), 32'd0);
    @(posedge sysclk); #1;
    @(negedge sysclk);
    check("en_ready_next_cycle", 32'(s_tready), 32'd1);
    @(posedge sysclk); #1;
    push_sample(16'h0000);
    wait_run();
    collect_bits(64, ones, b0, b1);
    check("zero_bit0", 32'(b0), 32'd0);
    check("zero_bit1", 32'(b1), 32'd1);
    check("zero_ones", 32'(ones), 32'd32);
    @(posedge sysclk); #1;

    // Positive full scale: 0 then 63 ones.
    start_fresh();
    push_sample(16'h7FFF);
    wait_run();
    collect_bits(64, ones, b0, b1);
    check("pfs_bit0", 32'(b0), 32'd0);
    check("pfs_ones", 32'(ones), 32'd63);
    @(posedge sysclk); #1;

    // Negative full scale then +0.5: 0 ones, then 48 per 64.
    start_fresh();
    push_sample(16'h8000);
    push_sample(16'h4000);
    wait_run();
    collect_bits(64, ones, b0, b1);
    check("nfs_ones", 32'(ones), 32'd0);
    collect_bits(64, ones, b0, b1);
    check("half_ones", 32'(ones), 32'd48);
    @(posedge sysclk); #1;

    // Underrun: single sample, then starvation.
    start_fresh();
    push_sample(16'h1234);
    wait_run();
    first_und = -1; n_und = 0; sd_low = 0;
    for (int i = 1; i <= 3 * OSR * CLK_DIV + 100; i++) begin
      @(negedge sysclk);
      if (underrun) begin
        n_und++;
        if (first_und < 0) first_und = i;
      end
      if (!aud_sd) sd_low++;
    end
    check("und_first_cycle", 32'(first_und), 32'(OSR * CLK_DIV));
    check("und_count",       32'(n_und),     32'd3);
    check("und_sd_low",      32'(sd_low),    32'd0);
    @(posedge sysclk); #1;

    // Backpressure with s_tvalid held high.
    start_fresh();
    s_tvalid = 1'b1;
    s_tdata  = 16'($urandom);
    n_acc = 0; n_early = 0;
    for (int i = 0; i < OSR * CLK_DIV + 60; i++) begin
      @(negedge sysclk);
      if (s_tvalid && s_tready) n_acc++;
      if (i == 40) n_early = n_acc;
      @(posedge sysclk); #1;
      s_tdata = 16'($urandom);
    end
    check("bp_early_accepts", 32'(n_early), 32'd5);
    check("bp_total_accepts", 32'(n_acc),   32'd6);

    // Stop mid-sample.
    @(negedge sysclk);
    check("stop_pre_level", 32'(fifo_level), 32'd4);
    check("stop_pre_sd",    32'(aud_sd),     32'd1);
    @(posedge sysclk); #1;
    enable = 1'b0;
    @(negedge sysclk);
    @(negedge sysclk);
    check("stop_aud_pwm",    32'(aud_pwm),    32'd0);
    check("stop_aud_sd",     32'(aud_sd),     32'd0);
    check("stop_fifo_level", 32'(fifo_level), 32'd0);
    check("stop_s_tready",   32'(s_tready),   32'd0);
    s_tvalid = 1'b0;
    @(posedge sysclk); #1;

    // Asynchronous reset between edges while outputs are active.
    start_fresh();
    push_sample(16'h7FFF);
    push_sample(16'h1111);
    wait_run();
    repeat (2 * CLK_DIV) @(negedge sysclk);
    check("arst_pre_pwm",   32'(aud_pwm),    32'd1);
    check("arst_pre_level", 32'(fifo_level), 32'd1);
    #2;
    sysreset_n = 1'b0;
    #1;
    check("arst_aud_pwm",    32'(aud_pwm),    32'd0);
    check("arst_aud_sd",     32'(aud_sd),     32'd0);
    check("arst_underrun",   32'(underrun),   32'd0);
    check("arst_s_tready",   32'(s_tready),   32'd0);
    check("arst_fifo_level", 32'(fifo_level), 32'd0);
    #20;
    @(posedge sysclk); #1;
    sysreset_n = 1'b1;

    // Randomized traffic: dense, then sparse (underruns), with enable drops.
    start_fresh();
    for (int i = 0; i < 15000; i++) begin
      if (i < 6000) s_tvalid = ($urandom_range(0, 99) < 90);
      else          s_tvalid = ((i % 3000) < 3);
      s_tdata = 16'($urandom);
      if (i == 2500 || i == 9000) enable = 1'b0;
      if (i == 2502 || i == 9005) enable = 1'b1;
      @(posedge sysclk); #1;
    end
    s_tvalid = 1'b0;
    repeat (4) @(posedge sysclk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
